// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with per-grant burst hold and back-to-back handoff.
// Optional burst limit: define RR_ARB_BURST_LIMIT_EN to force release after MAX_BURST cycles.

module rr_burst_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8,
  localparam int unsigned IW       = $clog2(N),
  localparam int unsigned CW       = $clog2(MAX_BURST + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic [CW-1:0] burst_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
  } pick_t;

  state_e        state_q;
  logic [IW-1:0] ptr_q;

  logic [IW-1:0] next_ptr;
  logic          handoff;
  pick_t         idle_pick;
  pick_t         hand_pick;

  // Scan from p with an explicit wrap at N-1 so non-power-of-2 N never yields idx >= N.
  function automatic pick_t pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    idx = p;
    for (int unsigned i = 0; i < N; i++) begin
      if (r[idx]) return '{valid: 1'b1, idx: idx};
      idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
    return '{valid: 1'b0, idx: '0};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  always_comb begin
    next_ptr  = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
`ifdef RR_ARB_BURST_LIMIT_EN
    handoff   = !req[gnt_id] || (burst_cnt == CW'(MAX_BURST));
`else
    handoff   = !req[gnt_id];
`endif
    idle_pick = pick(req, ptr_q);
    // A still-requesting owner is seen last, so a sole requester is simply re-granted.
    hand_pick = pick(req, next_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_pick.valid) begin
            gnt       <= onehot(idle_pick.idx);
            gnt_valid <= 1'b1;
            gnt_id    <= idle_pick.idx;
            burst_cnt <= CW'(1);
            state_q   <= StGrant;
          end
        end
        StGrant: begin
          if (handoff) begin
            ptr_q <= next_ptr;
            if (hand_pick.valid) begin
              gnt       <= onehot(hand_pick.idx);
              gnt_valid <= 1'b1;
              gnt_id    <= hand_pick.idx;
              burst_cnt <= CW'(1);
            end else begin
              gnt       <= '0;
              gnt_valid <= 1'b0;
              gnt_id    <= '0;
              burst_cnt <= '0;
              state_q   <= StIdle;
            end
          end else if (burst_cnt != '1) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
